// File: rtl/issue_unit_pkg.sv
// issue_unit_pkg
// Shared definitions for the issue unit slice: queue index constants, the
// default tag width and latencies, the tag typedef and a one-hot to index
// helper used by both the top level and the arbiter.
package issue_unit_pkg;

  localparam int TAG_W_DEF    = 6;
  localparam int LDST_LAT_DEF = 2;
  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 8;

  localparam int NUM_Q = 4;

  // Queue indices. They are also the bit positions in every per-queue vector.
  localparam logic [1:0] Q_INT  = 2'd0;
  localparam logic [1:0] Q_LDST = 2'd1;
  localparam logic [1:0] Q_MULT = 2'd2;
  localparam logic [1:0] Q_DIV  = 2'd3;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  // Encodes a one-hot (or all-zero) 4-bit vector; all-zero maps to 0.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      4'b0010: idx = Q_LDST;
      4'b0100: idx = Q_MULT;
      4'b1000: idx = Q_DIV;
      default: idx = Q_INT;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/issue_unit_if.sv
// issue_unit_if
// Bundles everything exchanged between the dispatch queues / CDB side and
// the issue unit, apart from clock and reset.
//   i_flush                      synchronous pipeline flush
//   i_q_empty                    per-queue empty flags (0 int, 1 ld/st, 2 mult, 3 div)
//   i_q_rs1_tag / i_q_rs2_tag    per-queue head source tags
//   i_q_rs1_rdy / i_q_rs2_rdy    per-queue head operand-valid bits from dispatch
//   i_cdb_valid / i_cdb_tag      common data bus broadcast
//   o_q_rd_en                    one-hot queue pop / issue strobe
//   o_issue_valid / o_issue_sel  issue indication and encoded queue index
//   o_div_busy                   divider occupied
// master: queue/CDB side (drives the inputs). slave: the issue unit.
interface issue_unit_if
  import issue_unit_pkg::*;
  #(parameter int TAG_W = TAG_W_DEF);

  logic                  i_flush;
  logic [3:0]            i_q_empty;
  logic [3:0][TAG_W-1:0] i_q_rs1_tag;
  logic [3:0][TAG_W-1:0] i_q_rs2_tag;
  logic [3:0]            i_q_rs1_rdy;
  logic [3:0]            i_q_rs2_rdy;
  logic                  i_cdb_valid;
  logic [TAG_W-1:0]      i_cdb_tag;
  logic [3:0]            o_q_rd_en;
  logic                  o_issue_valid;
  logic [1:0]            o_issue_sel;
  logic                  o_div_busy;

  modport master (
    output i_flush, i_q_empty, i_q_rs1_tag, i_q_rs2_tag,
           i_q_rs1_rdy, i_q_rs2_rdy, i_cdb_valid, i_cdb_tag,
    input  o_q_rd_en, o_issue_valid, o_issue_sel, o_div_busy
  );

  modport slave (
    input  i_flush, i_q_empty, i_q_rs1_tag, i_q_rs2_tag,
           i_q_rs1_rdy, i_q_rs2_rdy, i_cdb_valid, i_cdb_tag,
    output o_q_rd_en, o_issue_valid, o_issue_sel, o_div_busy
  );

endinterface

// File: rtl/issue_unit_arbiter.sv
// issue_arbiter
// Four-request arbiter with a one-hot grant.
//   clk, rst, flush  only present for the round-robin build (pointer register)
//   req              request per queue
//   grant            one-hot grant, zero when no request
// Configuration macro ISSUE_RR_EN: defined selects round-robin starting at a
// 2-bit pointer that moves to the slot after the granted one; undefined
// selects fixed priority int > ld/st > mult > div with no state at all.
module issue_arbiter
  import issue_unit_pkg::*;
(
`ifdef ISSUE_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
`endif
  input  logic [3:0] req,
  output logic [3:0] grant
);

`ifdef ISSUE_RR_EN
  logic [1:0] ptr;
  logic       found;

  // Scan the four requests starting at the pointer, wrapping modulo 4.
  always_comb begin
    grant = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        grant[ptr + 2'(i)] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  // Pointer holds while idle so an unused cycle does not skip anyone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd0;
    end else if (flush) begin
      ptr <= 2'd0;
    end else if (|grant) begin
      ptr <= onehot_to_idx(grant) + 2'd1;
    end
  end
`else
  always_comb begin
    grant    = 4'b0000;
    grant[0] = req[0];
    grant[1] = req[1] & ~req[0];
    grant[2] = req[2] & ~req[1] & ~req[0];
    grant[3] = req[3] & ~req[2] & ~req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/issue_unit.sv
// issue_unit
// Reader side of the four execution queues (int, ld/st, mult, div). Checks
// operand readiness of each queue head (dispatch valid bits, captured CDB
// tags, or same-cycle CDB bypass), structural availability (divider) and
// the CDB write-back reservation, then pops/issues at most one head a cycle.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    issue_unit_if.slave (queue heads, CDB, flush, issue outputs)
// Configuration macro ISSUE_RR_EN selects round-robin arbitration instead of
// fixed priority (see issue_arbiter).
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int TAG_W    = TAG_W_DEF,
  parameter int LDST_LAT = LDST_LAT_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input logic         i_clk,
  input logic         i_rst,
  issue_unit_if.slave bus
);

  logic [3:0][TAG_W-1:0] rs1_tag;
  logic [3:0][TAG_W-1:0] rs2_tag;
  logic [TAG_W-1:0]      cdb_tag;

  logic [3:0] match1;
  logic [3:0] match2;
  logic [3:0] cap1;
  logic [3:0] cap2;
  logic [3:0] rdy1;
  logic [3:0] rdy2;
  logic [3:0] slot_busy;
  logic [3:0] eligible;
  logic [3:0] req;
  logic [3:0] grant;

  logic [DIV_LAT:1] res;
  logic [DIV_LAT:1] res_shift;
  logic [DIV_LAT:1] res_set;

  logic [3:0] div_cnt;
  logic       div_busy;

  assign rs1_tag = bus.i_q_rs1_tag;
  assign rs2_tag = bus.i_q_rs2_tag;
  assign cdb_tag = bus.i_cdb_tag;

  // Tag matches against the current heads; an empty queue's head is stale
  // and must neither capture nor bypass.
  always_comb begin
    match1 = 4'b0000;
    match2 = 4'b0000;
    for (int q = 0; q < NUM_Q; q++) begin
      match1[q] = bus.i_cdb_valid & ~bus.i_q_empty[q] & (cdb_tag == rs1_tag[q]);
      match2[q] = bus.i_cdb_valid & ~bus.i_q_empty[q] & (cdb_tag == rs2_tag[q]);
    end
  end

  assign rdy1 = bus.i_q_rs1_rdy | cap1 | match1;
  assign rdy2 = bus.i_q_rs2_rdy | cap2 | match2;

  // The reservation check is made against the shifted image, i.e. the view
  // the vector will have once this cycle's shift is applied. That is the
  // same image the new reservation is written into, so res[L] tested here
  // and res[L] set on issue refer to the same CDB cycle (now + L).
  assign res_shift = {1'b0, res[DIV_LAT:2]};

  assign slot_busy = {res_shift[DIV_LAT], res_shift[MULT_LAT],
                      res_shift[LDST_LAT], res_shift[1]};

  assign div_busy = (div_cnt != 4'd0);

  assign eligible = ~bus.i_q_empty & rdy1 & rdy2 & ~slot_busy
                  & {~div_busy, 3'b111};

  // Flush suppresses every request so nothing pops in the flush cycle.
  assign req = bus.i_flush ? 4'b0000 : eligible;

  issue_arbiter u_arbiter (
`ifdef ISSUE_RR_EN
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (bus.i_flush),
`endif
    .req   (req),
    .grant (grant)
  );

  // New reservation for whichever queue was granted (grant is one-hot).
  always_comb begin
    res_set = '0;
    if (grant[Q_INT])  res_set[1]        = 1'b1;
    if (grant[Q_LDST]) res_set[LDST_LAT] = 1'b1;
    if (grant[Q_MULT]) res_set[MULT_LAT] = 1'b1;
    if (grant[Q_DIV])  res_set[DIV_LAT]  = 1'b1;
  end

  // Captures are sticky until their head pops; the pop clears even a match
  // arriving in the same cycle, since that match belonged to the old head.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap1 <= 4'b0000;
      cap2 <= 4'b0000;
    end else if (bus.i_flush) begin
      cap1 <= 4'b0000;
      cap2 <= 4'b0000;
    end else begin
      cap1 <= (cap1 | match1) & ~grant;
      cap2 <= (cap2 | match2) & ~grant;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      res <= '0;
    end else if (bus.i_flush) begin
      res <= '0;
    end else begin
      res <= res_shift | res_set;
    end
  end

  // Loaded with DIV_LAT-1 so the next divide can issue exactly DIV_LAT
  // cycles after the previous one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt <= 4'd0;
    end else if (bus.i_flush) begin
      div_cnt <= 4'd0;
    end else if (grant[Q_DIV]) begin
      div_cnt <= 4'(DIV_LAT - 1);
    end else if (div_busy) begin
      div_cnt <= div_cnt - 4'd1;
    end
  end

  assign bus.o_q_rd_en     = grant;
  assign bus.o_issue_valid = |grant;
  assign bus.o_issue_sel   = onehot_to_idx(grant);
  assign bus.o_div_busy    = div_busy;

endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit
// Self-checking bench for issue_unit. Expected pop vectors are queued when a
// cycle's stimulus is driven and popped/compared at the following falling
// edge, once the combinational issue decision has settled.
module tb_issue_unit;
  import issue_unit_pkg::*;

  localparam int TAG_W    = 6;
  localparam int LDST_LAT = 2;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  always #5 clk = ~clk;

  issue_unit_if #(.TAG_W(TAG_W)) bus ();

  issue_unit #(
    .TAG_W    (TAG_W),
    .LDST_LAT (LDST_LAT),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic logic [1:0] exp_sel(input logic [3:0] oh);
    if (oh[3]) return 2'd3;
    if (oh[2]) return 2'd2;
    if (oh[1]) return 2'd1;
    return 2'd0;
  endfunction

  // Drives one cycle of stimulus just after the rising edge, records the
  // expected pop vector and waits for the falling edge.
  task automatic cycle(input logic [3:0] empty, input logic [3:0] r1,
                       input logic [3:0] r2, input logic cv,
                       input logic [5:0] ct, input logic fl,
                       input logic [3:0] exp_rd);
    @(posedge clk);
    #1;
    bus.i_q_empty   = empty;
    bus.i_q_rs1_rdy = r1;
    bus.i_q_rs2_rdy = r2;
    bus.i_cdb_valid = cv;
    bus.i_cdb_tag   = ct;
    bus.i_flush     = fl;
    exp_q.push_back(exp_rd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      cycle(4'hF, 4'h0, 4'h0, 1'b0, 6'd0, 1'b0, 4'h0);
      d = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_q_empty = 4'hF; bus.i_q_rs1_rdy = 4'h0; bus.i_q_rs2_rdy = 4'h0;
    bus.i_cdb_valid = 1'b0; bus.i_cdb_tag = 6'd0; bus.i_flush = 1'b0;
    for (int q = 0; q < 4; q++) begin
      bus.i_q_rs1_tag[q] = 6'(40 + q);
      bus.i_q_rs2_tag[q] = 6'(50 + q);
    end
    @(negedge clk);
    checks++; if (bus.o_q_rd_en !== 4'h0) $display("[TB] FAIL reset_rd_en: got %b expected 0000", bus.o_q_rd_en); else passed++;
    checks++; if (bus.o_issue_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.o_issue_valid); else passed++;
    checks++; if (bus.o_issue_sel !== 2'd0) $display("[TB] FAIL reset_sel: got %0d expected 0", bus.o_issue_sel); else passed++;
    checks++; if (bus.o_div_busy !== 1'b0) $display("[TB] FAIL reset_div_busy: got %b expected 0", bus.o_div_busy); else passed++;
    checks++; if (dut.res !== '0) $display("[TB] FAIL reset_res: got %b expected 0", dut.res); else passed++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_int_issue();
    cycle(4'b1110, 4'b0001, 4'b0001, 1'b0, 6'd0, 1'b0, 4'b0001);
    e = exp_q.pop_front();
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL int_rd_en: got %b expected %b", bus.o_q_rd_en, e); else passed++;
    checks++; if (bus.o_issue_sel !== exp_sel(e)) $display("[TB] FAIL int_sel: got %0d expected %0d", bus.o_issue_sel, exp_sel(e)); else passed++;
    checks++; if (bus.o_issue_valid !== 1'b1) $display("[TB] FAIL int_valid: got %b expected 1", bus.o_issue_valid); else passed++;
    // Stale but "ready" heads in empty queues, CDB hitting a stale tag.
    cycle(4'hF, 4'hF, 4'hF, 1'b1, 6'd40, 1'b0, 4'b0000);
    e = exp_q.pop_front();
    checks++; if (dut.res[1] !== 1'b1) $display("[TB] FAIL int_res1: got %b expected 1", dut.res[1]); else passed++;
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL stale_rd_en: got %b expected %b", bus.o_q_rd_en, e); else passed++;
    idle(1);
    checks++; if (dut.cap1 !== 4'h0) $display("[TB] FAIL stale_cap: got %b expected 0000", dut.cap1); else passed++;
  endtask

  task automatic test_cdb_bypass();
    logic [3:0] tbl_r2 [7];
    logic       tbl_cv [7];
    logic [5:0] tbl_ct [7];
    logic [3:0] tbl_em [7];
    logic [3:0] tbl_ex [7];
    idle(10);
    bus.i_q_rs1_tag[2] = 6'd5;
    bus.i_q_rs2_tag[2] = 6'd7;
    // 0 wait, 1 bypass, 2 pulse while empty, 3-4 no recapture, 5 bypass,
    // 6 capture rs1 only; then rs2 bypass uses the held rs1 capture.
    tbl_em = '{4'b1011, 4'b1011, 4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
    tbl_r2 = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    tbl_cv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl_ct = '{6'd0, 6'd5, 6'd5, 6'd0, 6'd0, 6'd5, 6'd5};
    tbl_ex = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      cycle(tbl_em[i], 4'b0000, tbl_r2[i], tbl_cv[i], tbl_ct[i], 1'b0, tbl_ex[i]);
      e = exp_q.pop_front();
      checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL cdb_step%0d: got %b expected %b", i, bus.o_q_rd_en, e); else passed++;
      if (e == 4'b0100) begin
        checks++; if (bus.o_issue_sel !== exp_sel(e)) $display("[TB] FAIL cdb_sel%0d: got %0d expected %0d", i, bus.o_issue_sel, exp_sel(e)); else passed++;
      end
    end
    cycle(4'b1011, 4'b0000, 4'b0000, 1'b1, 6'd7, 1'b0, 4'b0100);
    e = exp_q.pop_front();
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL cdb_held_capture: got %b expected %b", bus.o_q_rd_en, e); else passed++;
  endtask

  task automatic test_back_to_back_div();
    idle(10);
    bus.i_q_rs1_tag[3] = 6'd9;
    bus.i_q_rs2_tag[3] = 6'd9;
    cycle(4'b0111, 4'b1000, 4'b1000, 1'b0, 6'd0, 1'b0, 4'b1000);
    e = exp_q.pop_front();
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL div_first: got %b expected %b", bus.o_q_rd_en, e); else passed++;
    // Second div's operands both arrive on one CDB tag while the divider is busy.
    for (int k = 1; k <= DIV_LAT; k++) begin
      cycle(4'b0111, 4'b0000, 4'b0000, (k == 1), (k == 1) ? 6'd9 : 6'd0, 1'b0,
            (k == DIV_LAT) ? 4'b1000 : 4'b0000);
      e = exp_q.pop_front();
      checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL div_t%0d_rd_en: got %b expected %b", k, bus.o_q_rd_en, e); else passed++;
      checks++; if (bus.o_div_busy !== (k < DIV_LAT)) $display("[TB] FAIL div_t%0d_busy: got %b expected %b", k, bus.o_div_busy, (k < DIV_LAT)); else passed++;
    end
    idle(1);
    checks++; if (bus.o_div_busy !== 1'b1) $display("[TB] FAIL div_second_busy: got %b expected 1", bus.o_div_busy); else passed++;
  endtask

  task automatic test_slot_conflict();
    logic [3:0] tbl_em [5];
    logic [3:0] tbl_r  [5];
    logic [3:0] tbl_ex [5];
    idle(10);
    tbl_em = '{4'b1011, 4'b1111, 4'b1111, 4'b1110, 4'b1110};
    tbl_r  = '{4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    tbl_ex = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    bus.i_q_rs1_tag[2] = 6'd42;
    for (int i = 0; i < 5; i++) begin
      cycle(tbl_em[i], tbl_r[i], tbl_r[i], 1'b0, 6'd0, 1'b0, tbl_ex[i]);
      e = exp_q.pop_front();
      checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL slot_t%0d: got %b expected %b", i, bus.o_q_rd_en, e); else passed++;
    end
  endtask

  task automatic test_flush();
    idle(10);
    bus.i_q_rs1_tag[2] = 6'd12;
    bus.i_q_rs2_tag[2] = 6'd13;
    cycle(4'b0111, 4'b1000, 4'b1000, 1'b0, 6'd0, 1'b0, 4'b1000);
    e = exp_q.pop_front();
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL flush_div_issue: got %b expected %b", bus.o_q_rd_en, e); else passed++;
    cycle(4'b1011, 4'b0000, 4'b0000, 1'b1, 6'd12, 1'b0, 4'b0000);
    e = exp_q.pop_front();
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL flush_capture_cycle: got %b expected %b", bus.o_q_rd_en, e); else passed++;
    cycle(4'b1010, 4'b0001, 4'b0001, 1'b0, 6'd0, 1'b1, 4'b0000);
    e = exp_q.pop_front();
    checks++; if (dut.cap1[2] !== 1'b1) $display("[TB] FAIL flush_cap_pending: got %b expected 1", dut.cap1[2]); else passed++;
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL flush_no_pop: got %b expected %b", bus.o_q_rd_en, e); else passed++;
    cycle(4'b0011, 4'b1000, 4'b1100, 1'b0, 6'd0, 1'b0, 4'b1000);
    e = exp_q.pop_front();
    checks++; if (bus.o_div_busy !== 1'b0) $display("[TB] FAIL flush_div_cnt: got busy %b expected 0", bus.o_div_busy); else passed++;
    checks++; if (dut.res !== '0) $display("[TB] FAIL flush_res: got %b expected 0", dut.res); else passed++;
    checks++; if ((dut.cap1 | dut.cap2) !== 4'h0) $display("[TB] FAIL flush_caps: got %b expected 0000", dut.cap1 | dut.cap2); else passed++;
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL flush_after: got %b expected %b", bus.o_q_rd_en, e); else passed++;
  endtask

  task automatic test_all_eligible();
    logic [3:0] order [4];
    idle(10);
`ifdef ISSUE_RR_EN
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`else
    order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    cycle(4'hF, 4'h0, 4'h0, 1'b0, 6'd0, 1'b1, 4'b0000);
    e = exp_q.pop_front();
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL all_flush: got %b expected %b", bus.o_q_rd_en, e); else passed++;
    for (int i = 0; i < 4; i++) begin
      cycle(4'h0, 4'hF, 4'hF, 1'b0, 6'd0, 1'b0, order[i]);
      e = exp_q.pop_front();
      checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL all_t%0d: got %b expected %b", i, bus.o_q_rd_en, e); else passed++;
      checks++; if (bus.o_issue_sel !== exp_sel(e)) $display("[TB] FAIL all_sel%0d: got %0d expected %0d", i, bus.o_issue_sel, exp_sel(e)); else passed++;
    end
  endtask

  task automatic test_reset_mid_div();
    idle(10);
    cycle(4'b0111, 4'b1000, 4'b1000, 1'b0, 6'd0, 1'b0, 4'b1000);
    e = exp_q.pop_front();
    checks++; if (bus.o_q_rd_en !== e) $display("[TB] FAIL rst_div_issue: got %b expected %b", bus.o_q_rd_en, e); else passed++;
    @(posedge clk);
    #1 bus.i_q_empty = 4'hF;
    checks++; if (bus.o_div_busy !== 1'b1) $display("[TB] FAIL rst_div_busy_before: got %b expected 1", bus.o_div_busy); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_div_busy !== 1'b0) $display("[TB] FAIL rst_div_abort: got %b expected 0", bus.o_div_busy); else passed++;
    checks++; if (dut.res !== '0) $display("[TB] FAIL rst_res: got %b expected 0", dut.res); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_int_issue();
    test_cdb_bypass();
    test_back_to_back_div();
    test_slot_conflict();
    test_flush();
    test_all_eligible();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
